prbs7_checker: RTL

Receive-side companion to the `prbs7_gen` generator. It consumes the serial PRBS7 bit stream (polynomial x^7 + x^6 + 1), self-synchronises a local LFSR to it, declares lock, and then counts bit errors against the locally predicted sequence. It sits directly downstream of the generator, or of any link carrying its output, and provides the pass/fail observability for link and loopback tests.

---
 rtl/prbs_pkg.sv | 14 +
 rtl/prbs7_lfsr_step.sv | 23 ++
 rtl/prbs7_checker.sv | 114 +++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS7 constants and checker state type, common to generator and checker.
package prbs_pkg;

  localparam int unsigned PRBS7_LEN   = 7;
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 5;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } prbs_state_t;

endpackage

// File: rtl/prbs7_lfsr_step.sv
// One step of the x^7 + x^6 + 1 LFSR: predicted bit and next state.
// Open loop feeds the prediction back; closed loop loads the received bit.
module prbs7_lfsr_step
  import prbs_pkg::*;
(
  input  logic [PRBS7_LEN-1:0] i_state,
  input  logic                 i_in_bit,
  input  logic                 i_open_loop,
  output logic                 o_pred,
  output logic [PRBS7_LEN-1:0] o_next
);

  logic w_pred;
  logic w_feed;

  always_comb begin
    w_pred = i_state[PRBS7_TAP_A] ^ i_state[PRBS7_TAP_B];
    w_feed = i_open_loop ? w_pred : i_in_bit;
    o_pred = w_pred;
    o_next = {i_state[PRBS7_LEN-2:0], w_feed};
  end

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: self-synchronises to the incoming stream, declares
// lock, then counts bit errors against the free-running local sequence.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             prbs_in,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0] FILL_LAST   = 3'(PRBS7_LEN - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

  prbs_state_t            r_state;
  logic [PRBS7_LEN-1:0]   r_s;
  logic [2:0]             r_fill;
  logic [7:0]             r_match;
  logic [7:0]             r_run;
  logic                   r_locked;
  logic                   r_err_pulse;
  logic [ERR_W-1:0]       r_err_cnt;

  logic                   w_pred;
  logic [PRBS7_LEN-1:0]   w_next;
  logic                   w_open;
  logic                   w_mismatch;

  assign w_open     = (r_state == LOCKED);
  assign w_mismatch = prbs_in ^ w_pred;

  prbs7_lfsr_step u_step (
    .i_state     (r_s),
    .i_in_bit    (prbs_in),
    .i_open_loop (w_open),
    .o_pred      (w_pred),
    .o_next      (w_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SEARCH;
      r_s         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (in_valid) begin
        r_s <= w_next;
        unique case (r_state)
          SEARCH: begin
            if (r_fill == FILL_LAST) begin
              r_fill <= '0;
              if (w_next != '0) begin
                r_state <= VERIFY;
                r_match <= '0;
              end
            end else begin
              r_fill <= r_fill + 3'd1;
            end
          end
          VERIFY: begin
            if (w_mismatch) begin
              r_state <= SEARCH;
              r_fill  <= '0;
            end else if (r_match == LOCK_LAST) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_run    <= '0;
            end else begin
              r_match <= r_match + 8'd1;
            end
          end
          LOCKED: begin
            if (w_mismatch) begin
              r_err_pulse <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
              if (r_run == UNLOCK_LAST) begin
                r_state  <= SEARCH;
                r_fill   <= '0;
                r_locked <= 1'b0;
              end else begin
                r_run <= r_run + 8'd1;
              end
            end else begin
              r_run <= '0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
      // Placed last so a clear overrides a coincident increment.
      if (clr_cnt) r_err_cnt <= '0;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule
